// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg - shared constants, types and parity helper for the
// rate-1/2, K=4 convolutional encoder and its matching Viterbi decoder.
//   CONV_K    constraint length (shift register holds CONV_K-1 bits)
//   CONV_G0   generator for p0, octal 17, bit 3 taps the input bit
//   CONV_G1   generator for p1, octal 15, bit 3 taps the input bit
//   TAIL_LEN  zero bits appended to terminate a frame in state 0
//   conv_enc_state_t  encoder FSM states
//   conv_parity(state, u)  returns the code symbol {p0, p1}
// The decoder branch-metric blocks import CONV_G0/CONV_G1 from here, so
// both ends of the link always agree on the code.
package conv_enc_pkg;

    localparam int         CONV_K   = 4;
    localparam logic [3:0] CONV_G0  = 4'b1111;
    localparam logic [3:0] CONV_G1  = 4'b1101;
    localparam int         TAIL_LEN = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } conv_enc_state_t;

    // state[2] is the most recent bit; taps are laid out as {u, s2, s1, s0}
    // so that the generator bit 3 lines up with the incoming bit.
    function automatic logic [1:0] conv_parity(input logic [CONV_K-2:0] state,
                                               input logic              u);
        logic [CONV_K-1:0] taps;
        taps = {u, state};
        return {^(taps & CONV_G0), ^(taps & CONV_G1)};
    endfunction

endpackage

// File: rtl/conv_enc_if.sv
// conv_enc_if - the two valid/ready streams of the convolutional encoder.
//   in_valid/in_ready/in_bit/in_last    information-bit stream into encoder
//   out_valid/out_ready/out_sym/out_last code-symbol stream out of encoder
// modport slave  : encoder side
// modport master : bit source / symbol sink side
interface conv_enc_if;

    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_last;

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_last
    );

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_last
    );

endinterface

// File: rtl/conv_enc_shreg.sv
// conv_enc_shreg - 3-bit encoder shift register plus parity generation.
//   clk, rst  clock and asynchronous active-low reset
//   advance   shift u into the register (one symbol produced)
//   clear     force the register to state 0 (wins over advance)
//   u         bit being encoded this cycle
//   parity    code symbol {p0, p1} for u against the current state
module conv_enc_shreg
    import conv_enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       clear,
    input  logic       u,
    output logic [1:0] parity
);

    logic [CONV_K-2:0] s_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_reg <= '0;
        end else if (clear) begin
            s_reg <= '0;
        end else if (advance) begin
            s_reg <= {u, s_reg[CONV_K-2:1]};
        end
    end

    assign parity = conv_parity(s_reg, u);

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder - framed rate-1/2, K=4 convolutional encoder.
//   clk, rst   clock and asynchronous active-low reset
//   enable     synchronous run enable; low clears to idle, dropping any frame
//   busy       a frame is in progress (DATA or TAIL)
//   bus        conv_enc_if.slave: bit stream in, registered symbol stream out
// Parameter FRAME_LEN (1..1024) caps the information bits per frame.
// Build option: define CONV_ENC_TAIL_EN to terminate every frame with
// TAIL_LEN zero bits; without it frames end unterminated and out_last marks
// the last data symbol.
module conv_encoder
    import conv_enc_pkg::*;
#(
    parameter int FRAME_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       busy,
    conv_enc_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_DATA  = 2'(DATA);
    localparam logic [1:0] ST_TAIL  = 2'(TAIL);
    localparam logic [9:0] LAST_IDX = 10'(FRAME_LEN - 1);

    logic [1:0] state_reg, state_next;
    logic [9:0] cnt_reg;
    logic       out_valid_reg;
    logic [1:0] out_sym_reg;
    logic       out_last_reg;

    logic       can_load, accept, frame_end, produce;
    logic       tail_done, sym_last, sr_clear, u;
    logic [1:0] parity;

    // The output register can take a new symbol when empty or draining.
    assign can_load     = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = enable && (state_reg != ST_TAIL) && can_load;
    assign accept       = bus.in_valid && bus.in_ready;
    // in_last and the length cap landing on the same bit are one frame end.
    assign frame_end    = accept && (bus.in_last || (cnt_reg == LAST_IDX));

`ifdef CONV_ENC_TAIL_EN
    localparam logic [1:0] ST_AFTER_DATA = ST_TAIL;

    logic [1:0] tail_cnt_reg;
    logic       tail_step;

    assign tail_step = enable && (state_reg == ST_TAIL) && can_load;
    assign tail_done = tail_step && (tail_cnt_reg == 2'(TAIL_LEN - 1));
    assign produce   = accept || tail_step;
    assign u         = (state_reg == ST_TAIL) ? 1'b0 : bus.in_bit;
    assign sym_last  = tail_done;
    // After the data bits the register keeps shifting through the zero
    // tail, so it only needs clearing once the tail has been flushed.
    assign sr_clear  = !enable || tail_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tail_cnt_reg <= '0;
        end else if (!enable || tail_done) begin
            tail_cnt_reg <= '0;
        end else if (tail_step) begin
            tail_cnt_reg <= tail_cnt_reg + 2'd1;
        end
    end
`else
    localparam logic [1:0] ST_AFTER_DATA = ST_IDLE;

    assign tail_done = 1'b0;
    assign produce   = accept;
    assign u         = bus.in_bit;
    assign sym_last  = frame_end;
    assign sr_clear  = !enable || frame_end;
`endif

    conv_enc_shreg u_shreg (
        .clk     (clk),
        .rst     (rst),
        .advance (produce),
        .clear   (sr_clear),
        .u       (u),
        .parity  (parity)
    );

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else if (accept) begin
            state_next = frame_end ? ST_AFTER_DATA : ST_DATA;
        end else if (tail_done) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (!enable || frame_end) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg <= cnt_reg + 10'd1;
            end
        end
    end

    // Symbol register: while stalled (valid && !ready) nothing is produced,
    // so symbol, last flag and all encoder state hold together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_sym_reg   <= 2'b00;
            out_last_reg  <= 1'b0;
        end else if (!enable) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (produce) begin
            out_valid_reg <= 1'b1;
            out_sym_reg   <= parity;
            out_last_reg  <= sym_last;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_sym   = out_sym_reg;
    assign bus.out_last  = out_last_reg;
    assign busy          = (state_reg == ST_DATA) || (state_reg == ST_TAIL);

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder - directed bench for conv_encoder with a scoreboard.
// The encoder is built with FRAME_LEN = 4 so the length cap is exercised.
// Expected symbols come from an independent reference encoder and are
// queued when a bit is accepted; a monitor pops and compares each symbol
// as it is consumed. Honours CONV_ENC_TAIL_EN like the design.
module tb_conv_encoder;

    localparam int FLEN = 4;
`ifdef CONV_ENC_TAIL_EN
    localparam bit TAIL_ON = 1'b1;
`else
    localparam bit TAIL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic busy;
    logic toggle_rdy;

    conv_enc_if bus ();

    conv_encoder #(.FRAME_LEN(FLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_sym  = 0;

    logic [2:0] exp_q[$];     // {sym[1:0], last}
    logic [2:0] m_s;          // reference shift register, [2] newest
    int         m_cnt;

    logic       stall_prev = 1'b0;
    logic [1:0] prev_sym;
    logic       prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] ref_par(input logic [2:0] s, input logic b);
        logic p0, p1;
        p0 = b ^ s[2] ^ s[1] ^ s[0];
        p1 = b ^ s[2] ^ s[0];
        return {p0, p1};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_s   = 3'b000;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic b, input logic last);
        logic       end_f;
        logic [2:0] s;
        end_f = last || (m_cnt + 1 == FLEN);
        exp_q.push_back({ref_par(m_s, b), end_f && !TAIL_ON});
        if (end_f) begin
            if (TAIL_ON) begin
                s = {b, m_s[2:1]};
                for (int k = 0; k < 3; k++) begin
                    exp_q.push_back({ref_par(s, 1'b0), (k == 2)});
                    s = {1'b0, s[2:1]};
                end
            end
            m_s   = 3'b000;
            m_cnt = 0;
        end else begin
            m_s   = {b, m_s[2:1]};
            m_cnt = m_cnt + 1;
        end
    endtask

    // Monitor: negedge sampling sees what the next rising edge will act on.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst && enable) begin
            if (stall_prev) begin
                chk("hold_valid", 32'(bus.out_valid), 32'(1'b1));
                chk("hold_sym",   32'(bus.out_sym),   32'(prev_sym));
                chk("hold_last",  32'(bus.out_last),  32'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_symbol observed=%b expected=none", bus.out_sym);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("symbol %0d: sym=%b last=%b (expected sym=%b last=%b)",
                             n_sym, bus.out_sym, bus.out_last, e[2:1], e[0]);
                    chk("out_sym",  32'(bus.out_sym),  32'(e[2:1]));
                    chk("out_last", 32'(bus.out_last), 32'(e[0]));
                    n_sym++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                model_accept(bus.in_bit, bus.in_last);
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_sym   = bus.out_sym;
            prev_last  = bus.out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // out_ready pattern generator, offset from the stimulus to avoid races.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (toggle_rdy) bus.out_ready = ~bus.out_ready;
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send_bit(input logic b, input logic last);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_last  = last;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        chk("accept_in_time", 32'(acc), 32'(1'b1));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // After a frame-ending bit with out_ready high: tail gap (if any) then idle.
    task automatic gap_check();
        logic exp_gap;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_gap = TAIL_ON && (k < 3);
            chk("gap_in_ready", 32'(bus.in_ready), 32'(!exp_gap));
            chk("gap_busy",     32'(busy),         32'(exp_gap));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
        #1;
    endtask

    initial begin
        int t0, cycles;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        toggle_rdy    = 1'b0;
        enable        = 1'b0;
        rst           = 1'b1;
        model_reset();

        // Reset values
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        chk("rst_out_sym",   32'(bus.out_sym),   32'(2'b00));
        chk("rst_out_last",  32'(bus.out_last),  32'(1'b0));
        chk("rst_busy",      32'(busy),          32'(1'b0));
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1'b0));
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 enable = 1'b1;

        // Frame 1,0,1,1 with in_last on the 4th bit (also the length cap)
        n_sym = 0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        gap_check();
        drain();
        chk("frame1_count", 32'(n_sym), 32'(4 + 3 * int'(TAIL_ON)));

        // Single-bit frame
        n_sym = 0;
        send_bit(1'b1, 1'b1);
        chk("single_sym",  32'(bus.out_sym),  32'(2'b11));
        chk("single_busy", 32'(busy),         32'(TAIL_ON));
        gap_check();
        drain();
        chk("single_count", 32'(n_sym), 32'(1 + 3 * int'(TAIL_ON)));

        // Backpressure: out_ready toggling during the 1,0,1,1 frame
        n_sym = 0;
        toggle_rdy = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        toggle_rdy    = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("bp_count", 32'(n_sym), 32'(4 + 3 * int'(TAIL_ON)));

        // Ten ones, no in_last: frames cut by the length cap
        t0 = int'($time);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        cycles = (int'($time) - t0) / 10;
        chk("ones_cycles", 32'(cycles), 32'(10 + 6 * int'(TAIL_ON)));

        // enable dropped right after the 2nd bit of the third frame
        enable = 1'b0;
        model_reset();
        #1;
        chk("en_low_in_ready", 32'(bus.in_ready), 32'(1'b0));
        @(posedge clk); #1;
        chk("en_low_out_valid", 32'(bus.out_valid), 32'(1'b0));
        chk("en_low_busy",      32'(busy),          32'(1'b0));
        #1 enable = 1'b1;
        send_bit(1'b1, 1'b1);
        chk("en_restart_sym",   32'(bus.out_sym),   32'(2'b11));
        chk("en_restart_valid", 32'(bus.out_valid), 32'(1'b1));
        gap_check();
        drain();

        // Asynchronous reset while the tail (or last symbol) is pending
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        chk("arst_out_sym",   32'(bus.out_sym),   32'(2'b00));
        chk("arst_out_last",  32'(bus.out_last),  32'(1'b0));
        chk("arst_busy",      32'(busy),          32'(1'b0));
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2;
        n_sym = 0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        gap_check();
        drain();
        chk("post_rst_count", 32'(n_sym), 32'(4 + 3 * int'(TAIL_ON)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
